alu_cmd_sequencer: RTL and testbench

//  Initiator side of the 16-bit ALU operand/result interface. Accepts operation

---
 rtl/alu_cmd_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Purpose:
//   Initiator side of a combinational ALU operand/result interface. Takes one
//   command at a time over a valid/ready handshake, drives the operands and
//   opcode onto the ALU from registers, waits SETTLE_CYC clock edges for the
//   ALU to settle, then captures result and flags into a tagged response that
//   is held under valid/ready until the consumer takes it.
//
//   FSM: IDLE -> SETTLE -> RESP -> IDLE.
//   The handshake edge in RESP returns to IDLE; cmd_ready rises the cycle
//   after, so there is no same-cycle response/command turnaround.
//
// Configuration macro:
//   ALU_SEQ_STATS_EN  defined   : saturating overflow/carry response counters
//                     undefined : no counter registers, counts tied to 0
//
// Parameters:
//   DATA_W      operand/result width (must match the ALU)
//   OP_W        opcode width (opcodes are not decoded here)
//   TAG_W       command tag width, echoed on the response
//   SETTLE_CYC  edges between driving the ALU and sampling it (1..15)
//   CNT_W       statistics counter width
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_a/cmd_b/cmd_op/cmd_tag command payload
//   alu_a/alu_b/alu_op         registered ALU operands/opcode
//   alu_result/carry/overflow/zero  ALU outputs
//   rsp_valid/rsp_ready        response handshake
//   rsp_result/carry/overflow/zero/tag  captured response
//   busy                       high whenever not IDLE
//   ovf_count/carry_count      saturating flag counters (stats build only)
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DATA_W     = 16,
    parameter int OP_W       = 4,
    parameter int TAG_W      = 4,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_overflow,
    output logic              rsp_zero,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy,
    output logic [CNT_W-1:0]  ovf_count,
    output logic [CNT_W-1:0]  carry_count
);

    // Settle counter is sized for the full legal SETTLE_CYC range (1..15).
    localparam int SC_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [SC_W-1:0]   r_settle_cnt;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_carry;
    logic              r_rsp_overflow;
    logic              r_rsp_zero;
    logic [TAG_W-1:0]  r_rsp_tag;

    logic w_accept;
    logic w_capture;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and handshake outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Command latch, settle timer and response capture
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_settle_cnt   <= '0;
            r_tag          <= '0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_op       <= '0;
            r_rsp_result   <= '0;
            r_rsp_carry    <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_rsp_tag      <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a      <= cmd_a;
                r_alu_b      <= cmd_b;
                r_alu_op     <= cmd_op;
                r_tag        <= cmd_tag;
                r_settle_cnt <= SC_W'(SETTLE_CYC - 1);
            end else if (r_state == S_SETTLE && r_settle_cnt != '0) begin
                r_settle_cnt <= r_settle_cnt - SC_W'(1);
            end

            // Response registers only load on the capture edge, so they are
            // inherently stable for the whole RESP state.
            if (w_capture) begin
                r_rsp_result   <= alu_result;
                r_rsp_carry    <= alu_carry;
                r_rsp_overflow <= alu_overflow;
                r_rsp_zero     <= alu_zero;
                r_rsp_tag      <= r_tag;
            end
        end
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign rsp_result   = r_rsp_result;
    assign rsp_carry    = r_rsp_carry;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_tag      = r_rsp_tag;

    // ---------------------------------------------------------------------
    // Optional statistics
    // ---------------------------------------------------------------------
`ifdef ALU_SEQ_STATS_EN
    logic [CNT_W-1:0] r_ovf_count;
    logic [CNT_W-1:0] r_carry_count;

    // Counters stop at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf_count   <= '0;
            r_carry_count <= '0;
        end else if (w_capture) begin
            if (alu_overflow && r_ovf_count != '1) begin
                r_ovf_count <= r_ovf_count + CNT_W'(1);
            end
            if (alu_carry && r_carry_count != '1) begin
                r_carry_count <= r_carry_count + CNT_W'(1);
            end
        end
    end

    assign ovf_count   = r_ovf_count;
    assign carry_count = r_carry_count;
`else
    assign ovf_count   = '0;
    assign carry_count = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Drives directed and random commands into alu_cmd_sequencer, with a
// behavioural 16-bit ALU attached to its ALU port. Expected responses,
// latency and statistics come from a transaction-level model.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    localparam int TB_S   = 3;
    localparam int TB_CW  = 2;
    localparam int CNT_MAX = (1 << TB_CW) - 1;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [3:0]  cmd_op;
    logic [3:0]  cmd_tag;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_carry;
    logic        alu_overflow;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_overflow;
    logic        rsp_zero;
    logic [3:0]  rsp_tag;
    logic        busy;
    logic [TB_CW-1:0] ovf_count;
    logic [TB_CW-1:0] carry_count;

    int n_checks = 0;
    int n_errors = 0;
    int m_ovf    = 0;
    int m_carry  = 0;

    alu_cmd_sequencer #(
        .DATA_W     (16),
        .OP_W       (4),
        .TAG_W      (4),
        .SETTLE_CYC (TB_S),
        .CNT_W      (TB_CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_op       (cmd_op),
        .cmd_tag      (cmd_tag),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .rsp_tag      (rsp_tag),
        .busy         (busy),
        .ovf_count    (ovf_count),
        .carry_count  (carry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: {carry, overflow, zero, result}.
    // ADD/SUB are two's-complement; carry on SUB means borrow.
    function automatic logic [18:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
        int unsigned sum;
        logic [15:0] r;
        logic c;
        logic v;
        int sa;
        int sb;
        int sr;
        sa = $signed(a);
        sb = $signed(b);
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                sum = int'(a) + int'(b);
                r = sum[15:0];
                c = (sum > 65535);
                sr = sa + sb;
                v = (sr > 32767) || (sr < -32768);
            end
            4'd1: begin
                r = a - b;
                c = (a < b);
                sr = sa - sb;
                v = (sr > 32767) || (sr < -32768);
            end
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            default: r = a;
        endcase
        return {c, v, (r == 16'd0), r};
    endfunction

    always_comb begin
        {alu_carry, alu_overflow, alu_zero, alu_result} = alu_f(alu_a, alu_b, alu_op);
    end

    function automatic int exp_cnt(input int v);
`ifdef ALU_SEQ_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_after_reset(input string tag);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_ovf_count"}, 32'(ovf_count), 32'd0);
        check_eq({tag, "_carry_count"}, 32'(carry_count), 32'd0);
        check_eq({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check_eq({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom % 6)
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // One complete command/response transaction. Entered and left at a
    // negedge in IDLE with cmd_valid low.
    task automatic do_cmd(input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] op, input logic [3:0] tag, input int hold);
        logic [18:0] e;
        for (int w = 0; w < 20 && !cmd_ready; w++) @(negedge clk);
        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_tag   = tag;
        rsp_ready = 1'($urandom);
        @(posedge clk);
        e = alu_f(a, b, op);
        if (e[17] && m_ovf < CNT_MAX) m_ovf++;
        if (e[18] && m_carry < CNT_MAX) m_carry++;

        // SETTLE: new commands must be ignored whatever cmd_valid does.
        for (int j = 0; j < TB_S; j++) begin
            @(negedge clk);
            check_eq("settle_rsp_valid", 32'(rsp_valid), 32'd0);
            check_eq("settle_cmd_ready", 32'(cmd_ready), 32'd0);
            check_eq("settle_busy", 32'(busy), 32'd1);
            if (j == 0) check_eq("alu_drive", {alu_op, alu_a, alu_b[11:0]}, {op, a, b[11:0]});
            cmd_valid = 1'($urandom);
            cmd_a     = 16'($urandom);
            cmd_b     = 16'($urandom);
            cmd_op    = 4'($urandom);
            cmd_tag   = 4'($urandom);
            rsp_ready = 1'($urandom);
        end

        @(negedge clk);
        check_eq("rsp_valid_latency", 32'(rsp_valid), 32'd1);
        check_eq("rsp_payload", {11'd0, rsp_carry, rsp_overflow, rsp_zero, rsp_result},
                 {13'd0, e});
        check_eq("rsp_tag", 32'(rsp_tag), 32'(tag));
        check_eq("ovf_count", 32'(ovf_count), 32'(exp_cnt(m_ovf)));
        check_eq("carry_count", 32'(carry_count), 32'(exp_cnt(m_carry)));
        cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check_eq("hold_payload", {8'd0, rsp_tag, rsp_carry, rsp_overflow, rsp_zero, rsp_result},
                     {9'd0, tag, e});
            rsp_ready = (h == hold - 1);
        end

        @(negedge clk);
        check_eq("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_hs_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("post_hs_busy", 32'(busy), 32'd0);
        check_eq("alu_keep", {alu_op, alu_a, alu_b[11:0]}, {op, a, b[11:0]});
        $display("txn a=%04h b=%04h op=%0d tag=%0d -> res=%04h c=%0b v=%0b z=%0b",
                 a, b, op, tag, e[15:0], e[18], e[17], e[16]);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    // Assert reset after 'wait_negs' negedges following an accept.
    task automatic reset_midflight(input string tag, input int wait_negs, input logic expect_rsp);
        cmd_valid = 1'b1;
        cmd_a     = 16'h8000;
        cmd_b     = 16'h8000;
        cmd_op    = 4'd0;
        cmd_tag   = 4'd9;
        rsp_ready = 1'b0;
        @(posedge clk);
        repeat (wait_negs) @(negedge clk);
        cmd_valid = 1'b0;
        check_eq({tag, "_pre_rsp_valid"}, 32'(rsp_valid), 32'(expect_rsp));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ovf   = 0;
        m_carry = 0;
        check_idle_after_reset(tag);
        @(negedge clk);
        check_eq({tag, "_discarded"}, 32'(rsp_valid), 32'd0);
        $display("txn reset during %s", tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        cmd_tag   = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_after_reset("reset");
        check_eq("reset_alu_op", 32'(alu_op), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_cmd(16'd10,   16'd5, 4'd0, 4'd3, 0);
        do_cmd(16'h7FFF, 16'd1, 4'd1, 4'd4, 0);   // SUB, no overflow
        do_cmd(16'h7FFF, 16'd1, 4'd0, 4'd5, 0);   // ADD overflow -> 8000
        do_cmd(16'h8000, 16'd1, 4'd1, 4'd6, 0);   // SUB overflow -> 7FFF
        do_cmd(16'd0,    16'd0, 4'd0, 4'd7, 0);   // zero flag
        do_cmd(16'h1234, 16'h00FF, 4'd2, 4'd8, 5); // backpressure, cmd_valid held
        do_cmd(16'hFFFF, 16'd1, 4'd0, 4'd9, 1);   // carry without overflow
        // Saturation: more overflows than the counter can hold
        for (int k = 0; k < 5; k++) begin
            do_cmd(16'h7FFF, 16'(k + 1), 4'd0, 4'(k), 0);
        end

        reset_midflight("settle", 1, 1'b0);
        reset_midflight("resp", TB_S + 1, 1'b1);

        // Random traffic
        for (int k = 0; k < 60; k++) begin
            do_cmd(pick_operand(), pick_operand(), 4'($urandom_range(0, 6)),
                   4'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
